// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer (right-to-left square-and-multiply).
// Drives the shared mod-reduction unit over a four-phase go/done handshake.
module mod_exp_ctrl #(
  parameter int W    = 32,
  parameter int BITS = 65
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [W-1:0]    base,
  input  logic [W-1:0]    exponent,
  input  logic [W-1:0]    modulus,
  output logic [W-1:0]    result,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [BITS-1:0] mod_x,
  output logic [BITS-1:0] mod_y,
  output logic            mod_go,
  input  logic [BITS-1:0] mod_m,
  input  logic            mod_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_CHECK, S_MUL, S_SQR, S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    P_ISSUE, P_WAIT, P_REL
  } phase_t;

  state_t state, state_d;
  phase_t phase, phase_d;

  logic [W-1:0]   acc, b, e, n;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] prod;
  logic           accept, issue, capture;
  logic           unused_m;

  assign unused_m = ^mod_m[BITS-1:W];

  // One shared multiplier: REDUCE sends b*1, MUL acc*b, SQR b*b
  assign op_a = (state == S_MUL) ? acc : b;
  assign op_b = (state == S_REDUCE) ? W'(1) : b;
  assign prod = (2*W)'(op_a) * (2*W)'(op_b);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      phase <= P_ISSUE;
    end else begin
      state <= state_d;
      phase <= phase_d;
    end
  end

  always_comb begin
    state_d = state;
    phase_d = phase;
    accept  = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (modulus == '0 || exponent == '0)
            state_d = S_FINISH;
          else
            state_d = S_REDUCE;
        end
      end
      S_CHECK: state_d = e[0] ? S_MUL : S_SQR;
      S_REDUCE, S_MUL, S_SQR: begin
        unique case (phase)
          P_ISSUE: begin
            if (!mod_done) begin
              issue   = 1'b1;
              phase_d = P_WAIT;
            end
          end
          P_WAIT: begin
            if (mod_done) begin
              capture = 1'b1;
              phase_d = P_REL;
            end
          end
          P_REL: begin
            if (!mod_done) begin
              phase_d = P_ISSUE;
              unique case (1'b1)
                state == S_MUL:
                  state_d = (e[W-1:1] == '0) ? S_FINISH : S_SQR;
                default: state_d = S_CHECK;
              endcase
            end
          end
          default: phase_d = P_ISSUE;
        endcase
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      mod_go <= 1'b0;
      mod_x  <= '0;
      mod_y  <= '0;
      acc    <= '0;
      b      <= '0;
      e      <= '0;
      n      <= '0;
    end else begin
      done <= (state == S_FINISH);
      if (accept) begin
        b    <= base;
        e    <= exponent;
        n    <= modulus;
        acc  <= (modulus == W'(0) || modulus == W'(1)) ? W'(0) : W'(1);
        err  <= 1'b0;
        busy <= 1'b1;
      end
      if (issue) begin
        mod_x  <= BITS'(prod);
        mod_y  <= BITS'(n);
        mod_go <= 1'b1;
      end
      if (capture) begin
        mod_go <= 1'b0;
        if (state == S_MUL)
          acc <= mod_m[W-1:0];
        else
          b <= mod_m[W-1:0];
        if (state == S_SQR)
          e <= e >> 1;
      end
      if (state == S_FINISH) begin
        result <= acc;
        busy   <= 1'b0;
        err    <= (n == '0);
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a randomised mod-unit responder.
// Expected results come from a left-to-right modpow model.
module tb_mod_exp_ctrl;

  localparam int W    = 32;
  localparam int BITS = 65;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [W-1:0]    base, exponent, modulus;
  logic [W-1:0]    result;
  logic            busy, done, err;
  logic [BITS-1:0] mod_x, mod_y, mod_m;
  logic            mod_go, mod_done;

  typedef struct {
    logic [W-1:0] res;
    logic         er;
    int           reqs;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int go_edges = 0;
  int go_base = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.W(W), .BITS(BITS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base(base), .exponent(exponent), .modulus(modulus),
    .result(result), .busy(busy), .done(done), .err(err),
    .mod_x(mod_x), .mod_y(mod_y), .mod_go(mod_go),
    .mod_m(mod_m), .mod_done(mod_done)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] bb,
                                           input logic [W-1:0] ee,
                                           input logic [W-1:0] nn);
    longint unsigned r, x, m;
    if (nn == 0) return '0;
    m = 64'(nn);
    r = 1 % m;
    x = 64'(bb) % m;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (ee[i]) r = (r * x) % m;
    end
    return W'(r);
  endfunction

  function automatic int ref_reqs(input logic [W-1:0] ee,
                                  input logic [W-1:0] nn);
    int msb;
    if (nn == 0 || ee == 0) return 0;
    msb = 0;
    for (int i = 0; i < W; i++) if (ee[i]) msb = i;
    return 1 + $countones(ee) + msb;
  endfunction

  // Behavioural mod unit
  initial begin
    logic [BITS-1:0] r;
    bit ok;
    mod_done = 1'b0;
    mod_m    = '0;
    forever begin
      @(negedge clk);
      if (mod_go && !mod_done) begin
        ok = 1'b1;
        for (int i = 0; i < $urandom_range(1, 20); i++) begin
          @(negedge clk);
          if (!mod_go) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          r = (mod_y == 0) ? '0 : mod_x % mod_y;
          r[BITS-1:W] = (BITS-W)'({$urandom(), $urandom()});
          mod_m    = r;
          mod_done = 1'b1;
          ok = 1'b0;
          for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!mod_go) begin
              ok = 1'b1;
              break;
            end
          end
          if (!ok) chk("go_drop_timeout", 64'(mod_go), 64'(0));
          repeat ($urandom_range(0, 4)) @(negedge clk);
          mod_done = 1'b0;
        end
      end
    end
  end

  // Handshake protocol watcher
  initial begin
    logic            prev_go;
    logic [BITS-1:0] prev_x, prev_y;
    prev_go = 1'b0;
    prev_x  = '0;
    prev_y  = '0;
    forever begin
      @(negedge clk);
      if (mod_go && !prev_go) begin
        go_edges++;
        chk("issue_while_done", 64'(mod_done), 64'(0));
      end
      if (mod_go && prev_go && (mod_x !== prev_x || mod_y !== prev_y)) begin
        tests++;
        fails++;
        $display("FAIL operand_stable: x %0h->%0h y %0h->%0h",
                 prev_x, mod_x, prev_y, mod_y);
      end
      prev_go = mod_go;
      prev_x  = mod_x;
      prev_y  = mod_y;
    end
  end

  // Result monitor
  initial begin
    exp_t ex;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && done) begin
        if (prev_done) chk("done_pulse_width", 64'(2), 64'(1));
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          ex = sb_q.pop_front();
          chk("result", 64'(result), 64'(ex.res));
          chk("err", 64'(err), 64'(ex.er));
          chk("req_count", 64'(go_edges - go_base), 64'(ex.reqs));
          chk("busy_at_done", 64'(busy), 64'(0));
        end
        go_base = go_edges;
      end
      prev_done = done;
    end
  end

  task automatic run(input logic [W-1:0] bb, input logic [W-1:0] ee,
                     input logic [W-1:0] nn, input logic [W-1:0] res,
                     input logic er, input int reqs);
    exp_t ex;
    @(negedge clk);
    start    = 1'b1;
    base     = bb;
    exponent = ee;
    modulus  = nn;
    ex.res   = res;
    ex.er    = er;
    ex.reqs  = reqs;
    sb_q.push_back(ex);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic run_model(input logic [W-1:0] bb, input logic [W-1:0] ee,
                           input logic [W-1:0] nn);
    run(bb, ee, nn, ref_pow(bb, ee, nn), nn == 0, ref_reqs(ee, nn));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 6000; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      chk("completion_timeout", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rb, re, rn;
    bit seen;
    reset_n  = 1'b0;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    modulus  = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_go", 64'(mod_go), 64'(0));
    chk("rst_x", 64'(mod_x), 64'(0));
    chk("rst_y", 64'(mod_y), 64'(0));
    reset_n = 1'b1;

    run(4, 13, 497, 445, 1'b0, 7);
    chk("busy_after_start", 64'(busy), 64'(1));
    wait_idle();

    run(65, 17, 3233, 2790, 1'b0, ref_reqs(17, 3233));
    wait_idle();
    run(2790, 413, 3233, 65, 1'b0, ref_reqs(413, 3233));
    wait_idle();

    // Reset while the first MUL request is outstanding
    run(4, 13, 497, 445, 1'b0, 7);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (mod_go && (go_edges - go_base) == 2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_mul", 64'(seen), 64'(1));
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_go", 64'(mod_go), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_result", 64'(result), 64'(0));
    reset_n = 1'b1;
    sb_q.delete();
    go_base = go_edges;
    run(4, 13, 497, 445, 1'b0, 7);
    wait_idle();

    run(123, 0, 497, 1, 1'b0, 0);
    chk("exp0_done_early", 64'(done), 64'(0));
    @(negedge clk);
    chk("exp0_done_at_2", 64'(done), 64'(1));
    wait_idle();
    run(9, 5, 1, 0, 1'b0, ref_reqs(5, 1));
    wait_idle();

    run(7, 3, 0, 0, 1'b1, 0);
    wait_idle();
    @(negedge clk);
    chk("err_held", 64'(err), 64'(1));
    run(3, 4, 11, 4, 1'b0, ref_reqs(4, 11));
    wait_idle();

    // Starts while busy must be ignored
    run(4, 13, 497, 445, 1'b0, 7);
    repeat (5) begin
      @(negedge clk);
      start    = 1'b1;
      base     = $urandom;
      exponent = $urandom;
      modulus  = $urandom;
      @(negedge clk);
      start    = 1'b0;
    end
    wait_idle();

    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 9))
        0:       rn = 0;
        1:       rn = 1;
        2, 3, 4: rn = $urandom_range(2, 1000);
        default: rn = $urandom;
      endcase
      re = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 300);
      rb = $urandom;
      run_model(rb, re, rn);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
